// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: ownership state encoding and port ids.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_grant.sv
// Combinational grant decision for the two data-memory requesters.
// Round-robin with a burst cap on the current owner, or strict port-0 priority.
module dmem_arbiter_grant
   import dmem_arbiter_pkg::*;
#(
   parameter int BURST_MAX  = 4,
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 3
) (
   input  logic [1:0]       req,
   input  arb_state_t       state,
   input  logic             last_gnt,
   input  logic [CNT_W-1:0] burst_cnt,
   output logic [1:0]       gnt
);

   localparam logic [CNT_W-1:0] CAP = CNT_W'(BURST_MAX);

   logic cap_hit;

   // The owner has used up its burst once BURST_MAX accepts have been counted.
   assign cap_hit = (burst_cnt >= CAP);

   always_comb begin
      gnt = 2'b00;
      if (FIXED_PRIO != 0) begin
         gnt[0] = req[0];
         gnt[1] = req[1] & ~req[0];
      end else begin
         case (state)
            ST_OWN0: begin
               if (req[0] && !(req[1] && cap_hit)) gnt[0] = 1'b1;
               else if (req[1])                   gnt[1] = 1'b1;
            end
            ST_OWN1: begin
               if (req[1] && !(req[0] && cap_hit)) gnt[1] = 1'b1;
               else if (req[0])                   gnt[0] = 1'b1;
            end
            default: begin
               // Tie from idle goes to the port that did not win last time.
               if (req[0] && (!req[1] || last_gnt == PORT1)) gnt[0] = 1'b1;
               else if (req[1])                              gnt[1] = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data BRAM between the CPU load/store path (port 0) and an
// external master (port 1); stalls the core while port 0 waits.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_MAX  = 4,
   parameter int FIXED_PRIO = 0
) (
   input  logic                    sysclk,
   input  logic                    rst,
   input  logic                    p0_req,
   input  logic                    p0_we,
   input  logic [DATA_WIDTH/8-1:0] p0_byte_en,
   input  logic [ADDR_WIDTH-1:0]   p0_addr,
   input  logic [DATA_WIDTH-1:0]   p0_wdata,
   output logic                    p0_gnt,
   output logic                    p0_rvalid,
   output logic [DATA_WIDTH-1:0]   p0_rdata,
   input  logic                    p1_req,
   input  logic                    p1_we,
   input  logic [DATA_WIDTH/8-1:0] p1_byte_en,
   input  logic [ADDR_WIDTH-1:0]   p1_addr,
   input  logic [DATA_WIDTH-1:0]   p1_wdata,
   output logic                    p1_gnt,
   output logic                    p1_rvalid,
   output logic [DATA_WIDTH-1:0]   p1_rdata,
   output logic                    cpu_stall,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_byte_w_en,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic [1:0]              dbg_state
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CAP = CNT_W'(BURST_MAX);

   // Handshake: a port is accepted in a cycle where req and gnt are both high.
   // Requests hold until accepted; gnt only ever goes to a requesting port.
   arb_state_t       state;
   arb_state_t       next_state;
   logic             last_gnt;
   logic [CNT_W-1:0] burst_cnt;
   logic [1:0]       rvalid_q;
   logic [1:0]       gnt_raw;
   logic [1:0]       gnt;

   dmem_arbiter_grant #(
      .BURST_MAX (BURST_MAX),
      .FIXED_PRIO(FIXED_PRIO),
      .CNT_W     (CNT_W)
   ) u_grant (
      .req      ({p1_req, p0_req}),
      .state    (state),
      .last_gnt (last_gnt),
      .burst_cnt(burst_cnt),
      .gnt      (gnt_raw)
   );

   // Grants are combinational, so they are masked to keep every output low in reset.
   assign gnt = gnt_raw & {2{rst}};

   always_comb begin
      next_state = ST_IDLE;
      if (gnt[0])      next_state = ST_OWN0;
      else if (gnt[1]) next_state = ST_OWN1;
   end

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         last_gnt  <= PORT1;
         burst_cnt <= '0;
         rvalid_q  <= 2'b00;
      end else begin
         state <= next_state;
         if (|gnt) last_gnt <= gnt[1];
         if (next_state == ST_IDLE)   burst_cnt <= '0;
         else if (next_state != state) burst_cnt <= CNT_W'(1);
         else if (burst_cnt < CAP)    burst_cnt <= burst_cnt + CNT_W'(1);
         rvalid_q <= gnt & ~{p1_we, p0_we};
      end
   end

   assign p0_gnt    = gnt[0];
   assign p1_gnt    = gnt[1];
   assign cpu_stall = rst & p0_req & ~gnt[0];
   assign dbg_state = state;

   always_comb begin
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_byte_w_en = '0;
      if (gnt[0]) begin
         mem_addr      = p0_addr;
         mem_wdata     = p0_wdata;
         mem_byte_w_en = p0_we ? p0_byte_en : {BE_W{1'b0}};
      end else if (gnt[1]) begin
         mem_addr      = p1_addr;
         mem_wdata     = p1_wdata;
         mem_byte_w_en = p1_we ? p1_byte_en : {BE_W{1'b0}};
      end
   end

   assign p0_rvalid = rvalid_q[0];
   assign p1_rvalid = rvalid_q[1];
   assign p0_rdata  = rvalid_q[0] ? mem_rdata : '0;
   assign p1_rdata  = rvalid_q[1] ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// request-level model of arbitration and memory contents.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int BM = 4;

   logic          sysclk = 1'b0;
   logic          rst;
   logic          p0_req, p0_we, p1_req, p1_we;
   logic [3:0]    p0_byte_en, p1_byte_en;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, cpu_stall;
   logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_byte_w_en;
   logic [1:0]    dbg_state;

   logic          fp_p0_req, fp_p1_req;
   logic          fp_p0_gnt, fp_p0_rvalid, fp_p1_gnt, fp_p1_rvalid, fp_cpu_stall;
   logic [DW-1:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata, fp_mem_rdata;
   logic [AW-1:0] fp_mem_addr;
   logic [3:0]    fp_mem_byte_w_en;
   logic [1:0]    fp_dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] bram    [0:(1<<AW)-1];
   logic [DW-1:0] exp_mem [0:(1<<AW)-1];
   logic          init_done = 1'b0;

   always #5 sysclk = ~sysclk;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM), .FIXED_PRIO(0)) u_dut (
      .sysclk(sysclk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_byte_en(p0_byte_en), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_byte_en(p1_byte_en), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_byte_w_en(mem_byte_w_en), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM), .FIXED_PRIO(1)) u_fp (
      .sysclk(sysclk), .rst(rst),
      .p0_req(fp_p0_req), .p0_we(1'b0), .p0_byte_en(4'h0), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
      .p1_req(fp_p1_req), .p1_we(1'b0), .p1_byte_en(4'h0), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
      .cpu_stall(fp_cpu_stall), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
      .mem_byte_w_en(fp_mem_byte_w_en), .mem_rdata(fp_mem_rdata), .dbg_state(fp_dbg_state)
   );

   assign fp_mem_rdata = '0;

   function automatic logic [DW-1:0] init_word(int i);
      if (i == 'h010) return 32'hDEADBEEF;
      if (i == 'h020) return 32'hAAAAAAAA;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Read-first synchronous BRAM model.
   always @(posedge sysclk) begin
      if (!init_done) begin
         for (int i = 0; i < (1 << AW); i++) bram[i] <= init_word(i);
      end else begin
         for (int b = 0; b < 4; b++)
            if (mem_byte_w_en[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= bram[mem_addr];
      end
   end

   task automatic idle_inputs();
      p0_req = 0; p0_we = 0; p0_byte_en = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_byte_en = 0; p1_addr = 0; p1_wdata = 0;
      fp_p0_req = 0; fp_p1_req = 0;
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      rst = 0;
      idle_inputs();
      @(negedge sysclk);
      rst = 1;
   endtask

   task automatic test_reset();
      rst = 0;
      idle_inputs();
      p0_req = 1; p0_addr = 12'h010;
      repeat (2) @(negedge sysclk);
      checks++;
      if ({p0_gnt, p1_gnt, cpu_stall, p0_rvalid, p1_rvalid} !== 5'b0 || mem_addr !== '0 ||
          mem_byte_w_en !== 4'h0 || mem_wdata !== '0 || p0_rdata !== '0 || p1_rdata !== '0) begin
         failures++;
         $display("FAIL reset_outputs: gnt=%b%b stall=%b rv=%b%b addr=%h be=%h, required all 0",
                  p0_gnt, p1_gnt, cpu_stall, p0_rvalid, p1_rvalid, mem_addr, mem_byte_w_en);
      end
      checks++;
      if (dbg_state !== 2'(ST_IDLE)) begin
         failures++;
         $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
      end
      rst = 1;
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_gnt: p0_gnt=%b p1_gnt=%b required 1 0", p0_gnt, p1_gnt);
      end
      @(negedge sysclk);
      p0_req = 0;
   endtask

   task automatic test_read();
      @(negedge sysclk);
      p0_req = 1; p0_we = 0; p0_addr = 12'h010;
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || mem_addr !== 12'h010 || mem_byte_w_en !== 4'h0) begin
         failures++;
         $display("FAIL read_cmd: gnt=%b addr=%h be=%h required 1 010 0", p0_gnt, mem_addr, mem_byte_w_en);
      end
      @(negedge sysclk);
      p0_req = 0;
      checks++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL read_data: rvalid=%b rdata=%h p1_rvalid=%b required 1 deadbeef 0",
                  p0_rvalid, p0_rdata, p1_rvalid);
      end
      @(negedge sysclk);
      checks++;
      if (p0_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL read_single_rvalid: p0_rvalid=%b required 0", p0_rvalid);
      end
   endtask

   task automatic test_round_robin();
      logic exp0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge sysclk);
         p0_req = 1; p1_req = 1; p0_we = 0; p1_we = 0;
         p0_addr = AW'($urandom_range(0, 255)); p1_addr = AW'($urandom_range(0, 255));
         #1;
         exp0 = ((i / BM) % 2) == 0;
         checks++;
         if (p0_gnt !== exp0 || p1_gnt !== !exp0 || cpu_stall !== !exp0) begin
            failures++;
            $display("FAIL rr_cycle%0d: gnt=%b%b stall=%b required gnt0=%b stall=%b",
                     i, p0_gnt, p1_gnt, cpu_stall, exp0, !exp0);
         end
      end
      @(negedge sysclk);
      idle_inputs();
   endtask

   task automatic test_fixed_prio();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge sysclk);
         fp_p0_req = 1; fp_p1_req = 1;
         #1;
         checks++;
         if (fp_p0_gnt !== 1'b1 || fp_p1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL fp_cycle%0d: gnt=%b%b required 10", i, fp_p0_gnt, fp_p1_gnt);
         end
      end
      @(negedge sysclk);
      fp_p0_req = 0;
      #1;
      checks++;
      if (fp_p1_gnt !== 1'b1 || fp_p0_gnt !== 1'b0) begin
         failures++;
         $display("FAIL fp_handover: gnt=%b%b required 01", fp_p0_gnt, fp_p1_gnt);
      end
      @(negedge sysclk);
      idle_inputs();
   endtask

   task automatic test_byte_write();
      @(negedge sysclk);
      p1_req = 1; p1_we = 1; p1_byte_en = 4'b0011; p1_addr = 12'h020; p1_wdata = 32'h12345678;
      #1;
      checks++;
      if (p1_gnt !== 1'b1 || mem_addr !== 12'h020 || mem_byte_w_en !== 4'b0011 || mem_wdata !== 32'h12345678) begin
         failures++;
         $display("FAIL bw_cmd: gnt=%b addr=%h be=%b wdata=%h required 1 020 0011 12345678",
                  p1_gnt, mem_addr, mem_byte_w_en, mem_wdata);
      end
      @(negedge sysclk);
      p1_req = 0; p1_we = 0;
      p0_req = 1; p0_we = 0; p0_addr = 12'h020;
      checks++;
      if (p1_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL bw_no_rvalid: p1_rvalid=%b required 0", p1_rvalid);
      end
      #1;
      checks++;
      if (p0_gnt !== 1'b1) begin
         failures++;
         $display("FAIL bw_read_gnt: p0_gnt=%b required 1", p0_gnt);
      end
      @(negedge sysclk);
      p0_req = 0;
      checks++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hAAAA5678) begin
         failures++;
         $display("FAIL bw_readback: rvalid=%b rdata=%h required 1 aaaa5678", p0_rvalid, p0_rdata);
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      @(negedge sysclk);
      p0_req = 1; p0_we = 0; p0_addr = 12'h030;
      #1;
      checks++;
      if (p0_gnt !== 1'b1) begin
         failures++;
         $display("FAIL rmr_gnt: p0_gnt=%b required 1", p0_gnt);
      end
      @(posedge sysclk);
      #1;
      rst = 0;
      p0_req = 0;
      @(negedge sysclk);
      checks++;
      if (p0_rvalid !== 1'b0 || p0_rdata !== '0) begin
         failures++;
         $display("FAIL rmr_rvalid: rvalid=%b rdata=%h required 0 0", p0_rvalid, p0_rdata);
      end
      rst = 1;
      @(negedge sysclk);
      checks++;
      if (dbg_state !== 2'(ST_IDLE) || p0_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rmr_after: state=%0d rvalid=%b required %0d 0", dbg_state, p0_rvalid, ST_IDLE);
      end
   endtask

   task automatic test_random();
      logic          rv   [2];
      logic          we   [2];
      logic [3:0]    be   [2];
      logic [AW-1:0] ad   [2];
      logic [DW-1:0] wd   [2];
      logic          exp_rv [2];
      logic [DW-1:0] exp_rd [2];
      int            prev_w, run, last_w, w;
      logic [AW-1:0] exp_addr;
      logic [3:0]    exp_be;
      do_reset();
      for (int i = 0; i < 16; i++) exp_mem[i] = bram[i];
      for (int p = 0; p < 2; p++) begin
         rv[p] = 0; we[p] = 0; be[p] = 0; ad[p] = 0; wd[p] = 0; exp_rv[p] = 0; exp_rd[p] = 0;
      end
      prev_w = -1; run = 0; last_w = 1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge sysclk);
         checks++;
         if (p0_rvalid !== exp_rv[0] || p1_rvalid !== exp_rv[1] ||
             (exp_rv[0] && p0_rdata !== exp_rd[0]) || (exp_rv[1] && p1_rdata !== exp_rd[1])) begin
            failures++;
            $display("FAIL rnd_rdata c%0d: rv=%b%b rd0=%h rd1=%h required rv=%b%b rd0=%h rd1=%h",
                     cyc, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]);
         end
         for (int p = 0; p < 2; p++) begin
            exp_rv[p] = 0;
            if (!rv[p] && $urandom_range(0, 99) < 60) begin
               rv[p] = 1;
               we[p] = 1'($urandom_range(0, 1));
               be[p] = 4'($urandom_range(0, 15));
               ad[p] = AW'($urandom_range(0, 15));
               wd[p] = $urandom;
            end
         end
         p0_req = rv[0]; p0_we = we[0]; p0_byte_en = be[0]; p0_addr = ad[0]; p0_wdata = wd[0];
         p1_req = rv[1]; p1_we = we[1]; p1_byte_en = be[1]; p1_addr = ad[1]; p1_wdata = wd[1];
         #1;
         // Winner from the rules: lone requester wins; on contention the previous
         // winner keeps going until it has had BURST_MAX accepts in a row.
         w = -1;
         if (rv[0] && !rv[1])      w = 0;
         else if (rv[1] && !rv[0]) w = 1;
         else if (rv[0] && rv[1]) begin
            if (prev_w >= 0) w = (run >= BM) ? 1 - prev_w : prev_w;
            else             w = 1 - last_w;
         end
         exp_addr = (w < 0) ? '0 : ad[w];
         exp_be   = (w < 0 || !we[w]) ? 4'h0 : be[w];
         checks++;
         if (p0_gnt !== (w == 0) || p1_gnt !== (w == 1) || cpu_stall !== (rv[0] && w != 0) ||
             mem_addr !== exp_addr || mem_byte_w_en !== exp_be) begin
            failures++;
            $display("FAIL rnd_grant c%0d: gnt=%b%b stall=%b addr=%h be=%h required winner=%0d addr=%h be=%h",
                     cyc, p0_gnt, p1_gnt, cpu_stall, mem_addr, mem_byte_w_en, w, exp_addr, exp_be);
         end
         if (w >= 0) begin
            run    = (w == prev_w) ? run + 1 : 1;
            prev_w = w;
            last_w = w;
            if (we[w]) begin
               for (int b = 0; b < 4; b++)
                  if (be[w][b]) exp_mem[ad[w]][8*b +: 8] = wd[w][8*b +: 8];
            end else begin
               exp_rv[w] = 1;
               exp_rd[w] = exp_mem[ad[w]];
            end
            rv[w] = 0;
         end else begin
            prev_w = -1;
            run    = 0;
         end
      end
      @(negedge sysclk);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 0;
      @(negedge sysclk);
      init_done = 1'b1;
      test_reset();
      test_read();
      test_round_robin();
      test_fixed_prio();
      test_byte_write();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
